// File: rtl/dct_pkg.sv
// Shared constants, FSM state type and helpers for the DCT line sequencer.
package dct_pkg;

  localparam int unsigned SAMPLE_W        = 8;
  localparam int unsigned N_POINTS        = 16;
  localparam int unsigned N_PAIRS         = 8;
  localparam int unsigned LINES_PER_BLOCK = 16;

  localparam int unsigned IDX_W      = $clog2(N_POINTS);
  localparam int unsigned PAIR_W     = $clog2(N_PAIRS);
  localparam int unsigned LINE_CNT_W = $clog2(LINES_PER_BLOCK + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FEED      = 3'd1,
    ST_WAIT_RDY  = 3'd2,
    ST_LAUNCH    = 3'd3,
    ST_WAIT_DONE = 3'd4
  } seq_state_e;

  // Index of the mirrored partner sample: 15-k.
  function automatic logic [IDX_W-1:0] mirror_idx(input logic [PAIR_W-1:0] k);
    return IDX_W'(N_POINTS - 1) - IDX_W'(k);
  endfunction

endpackage

// File: rtl/dct_line_bank.sv
// Ping-pong pair of 16-sample line banks: serial capture side plus a
// mirrored pair read port (x[k], x[15-k]) for the bank being replayed.
module dct_line_bank
  import dct_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [PAIR_W-1:0]   rd_k,
  input  logic                rd_release,
  output logic                rd_full,
  output logic [SAMPLE_W-1:0] pair_a,
  output logic [SAMPLE_W-1:0] pair_b
);

  logic [SAMPLE_W-1:0] mem_q [2][N_POINTS];
  logic [SAMPLE_W-1:0] mem_d [2][N_POINTS];
  logic [1:0]          full_q, full_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic                accept;

  assign s_ready = ~full_q[wr_bank_q];
  assign rd_full = full_q[rd_bank_q];
  assign accept  = s_valid & s_ready;
  assign pair_a  = mem_q[rd_bank_q][IDX_W'(rd_k)];
  assign pair_b  = mem_q[rd_bank_q][mirror_idx(rd_k)];

  // Next-state for capture pointers, full flags and bank contents.
  // Set and release always target different banks: a set needs !full.
  always_comb begin
    mem_d     = mem_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    if (accept) begin
      mem_d[wr_bank_q][wr_idx_q] = s_data;
      wr_idx_d                   = wr_idx_q + 1'b1;
      if (wr_idx_q == IDX_W'(N_POINTS - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (rd_release) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // Control registers; reset drops any partial or pending line.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

  // Sample storage; contents are only meaningful while the full flag is set.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dct_line_sequencer.sv
// Line sequencer: replays each captured line as 8 mirrored pairs into the
// DCT input buffer, launches the core, and counts lines per block.
module dct_line_sequencer #(
  parameter int unsigned SAMPLE_W        = 8,
  parameter int unsigned LINES_PER_BLOCK = 16,
  parameter int unsigned RDY_TIMEOUT     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [SAMPLE_W-1:0]            s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic                           buf_start,
  output logic [SAMPLE_W-1:0]            buf_in_a,
  output logic [SAMPLE_W-1:0]            buf_in_b,
  input  logic                           buf_ready,
  output logic                           core_start,
  input  logic                           core_done,
  output logic [dct_pkg::LINE_CNT_W-1:0] line_cnt,
  output logic                           block_done,
  output logic                           busy,
  output logic                           err
);

  import dct_pkg::*;

  localparam int unsigned WAIT_W = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1;

  seq_state_e            state_q, state_d;
  logic [PAIR_W-1:0]     k_q, k_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [SAMPLE_W-1:0]   in_a_q, in_a_d, in_b_q, in_b_d;
  logic                  start_q, start_d;
  logic                  core_start_q, core_start_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic                  block_done_q, block_done_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic [PAIR_W-1:0]     rd_k;
  logic                  rd_release;
  logic                  rd_full;
  logic [SAMPLE_W-1:0]   pair_a, pair_b;

  dct_line_bank u_bank (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .rd_k       (rd_k),
    .rd_release (rd_release),
    .rd_full    (rd_full),
    .pair_a     (pair_a),
    .pair_b     (pair_b)
  );

  // FSM next-state and registered outputs. The read port is addressed one
  // pair ahead so the pair for index k is on the outputs while state is FEED/k.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    wait_d       = wait_q;
    in_a_d       = in_a_q;
    in_b_d       = in_b_q;
    start_d      = 1'b0;
    core_start_d = 1'b0;
    line_cnt_d   = line_cnt_q;
    block_done_d = 1'b0;
    err_d        = err_q;
    rd_release   = 1'b0;
    rd_k         = k_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        rd_k = '0;
        if (rd_full) begin
          state_d = ST_FEED;
          k_d     = '0;
          in_a_d  = pair_a;
          in_b_d  = pair_b;
          start_d = 1'b1;
        end
      end
      ST_FEED: begin
        if (k_q != PAIR_W'(N_PAIRS - 1)) begin
          k_d    = k_q + 1'b1;
          in_a_d = pair_a;
          in_b_d = pair_b;
        end else begin
          rd_release = 1'b1;
          wait_d     = '0;
          state_d    = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (buf_ready) begin
          state_d      = ST_LAUNCH;
          core_start_d = 1'b1;
        end else if (wait_q == WAIT_W'(RDY_TIMEOUT - 1)) begin
          err_d        = 1'b1;
          state_d      = ST_LAUNCH;
          core_start_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (core_done) begin
          state_d = ST_IDLE;
          if (line_cnt_q == LINE_CNT_W'(LINES_PER_BLOCK - 1)) begin
            line_cnt_d   = '0;
            block_done_d = 1'b1;
          end else begin
            line_cnt_d = line_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      wait_q       <= '0;
      in_a_q       <= '0;
      in_b_q       <= '0;
      start_q      <= 1'b0;
      core_start_q <= 1'b0;
      line_cnt_q   <= '0;
      block_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      wait_q       <= wait_d;
      in_a_q       <= in_a_d;
      in_b_q       <= in_b_d;
      start_q      <= start_d;
      core_start_q <= core_start_d;
      line_cnt_q   <= line_cnt_d;
      block_done_q <= block_done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign buf_start  = start_q;
  assign buf_in_a   = in_a_q;
  assign buf_in_b   = in_b_q;
  assign core_start = core_start_q;
  assign line_cnt   = line_cnt_q;
  assign block_done = block_done_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
